// File: rtl/sine_anim_if.sv
// sine_anim_if: signal bundle between the VGA timing / control side and the
// sine overlay animation controller.
//   vsync      vertical sync, active high (master -> slave)
//   enable     1 = animate, 0 = park overlay at home (master -> slave)
//   pause      level, freezes the animation (master -> slave)
//   step_req   1-cycle pulse, single step while paused (master -> slave)
//   speed      phase increment per step = 1<<speed (master -> slave)
//   origin_x   overlay x origin (slave -> master)
//   origin_y   overlay y origin (slave -> master)
//   phase      scroll phase 0..127 (slave -> master)
//   frame_tick 1-cycle pulse when a new origin is committed (slave -> master)
interface sine_anim_if;
  logic       vsync;
  logic       enable;
  logic       pause;
  logic       step_req;
  logic [1:0] speed;
  logic [9:0] origin_x;
  logic [9:0] origin_y;
  logic [6:0] phase;
  logic       frame_tick;

  modport master (
    output vsync, enable, pause, step_req, speed,
    input  origin_x, origin_y, phase, frame_tick
  );

  modport slave (
    input  vsync, enable, pause, step_req, speed,
    output origin_x, origin_y, phase, frame_tick
  );
endinterface

// File: rtl/sine_anim_ctrl.sv
// sine_anim_ctrl: per-frame animation controller for the sine overlay layer.
// Detects frame start on the vsync rising edge and commits a new overlay
// origin and wave phase once every FRAME_DIV frames. Outputs only change on
// a frame start so the overlay never tears within a frame.
//
// Ports:
//   clk  pixel clock
//   rst  synchronous, active-high reset
//   bus  sine_anim_if.slave (vsync/enable/pause/step_req/speed in,
//        origin_x/origin_y/phase/frame_tick out, all outputs registered)
//
// Build option: define SINE_ANIM_BOUNCE_EN to make origin_y bounce between
// Y_MIN and Y_MAX by one pixel per step. Without it origin_y stays at Y_HOME
// and only x scrolls.
//
// state  | meaning
// IDLE   | overlay parked at home, re-parked on every frame start
// RUN    | one animation step every FRAME_DIV frame starts
// PAUSED | frozen; a step_req buys exactly one step at the next frame start
module sine_anim_ctrl #(
  parameter int X_HOME    = 374,
  parameter int Y_HOME    = 96,
  parameter int Y_MIN     = 32,
  parameter int Y_MAX     = 400,
  parameter int FRAME_DIV = 2
) (
  input  logic     clk,
  input  logic     rst,
  sine_anim_if.slave bus
);

  localparam int DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAME_DIV - 1);
  localparam logic [9:0] X_HOME_V = 10'(X_HOME);
  localparam logic [9:0] Y_HOME_V = 10'(Y_HOME);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_PAUSED = 2'd2
  } state_t;

  state_t           state;
  logic [6:0]       phase_q;
  logic [9:0]       origin_x_q;
  logic [9:0]       origin_y_q;
  logic [DIV_W-1:0] div_cnt;
  logic             step_pend;
  logic             vsync_q;
  logic             frame_tick_q;

  logic             frame_start;
  logic             park_change;
  logic [6:0]       step_phase;
  logic [9:0]       step_x;
  logic [9:0]       step_y;

`ifdef SINE_ANIM_BOUNCE_EN
  logic             dir_down;
  logic             step_dir;
`endif

  assign frame_start = bus.vsync & ~vsync_q;

  // A park only pulses frame_tick when it actually moves the overlay.
  assign park_change = (phase_q != 7'd0) || (origin_x_q != X_HOME_V) ||
                       (origin_y_q != Y_HOME_V);

  // Next-step values, used by both RUN and PAUSED.
  always_comb begin
    step_phase = phase_q + (7'd1 << bus.speed);
    step_x     = X_HOME_V - {3'b000, step_phase};
    step_y     = origin_y_q;
`ifdef SINE_ANIM_BOUNCE_EN
    step_dir   = dir_down;
    if (dir_down) begin
      if (origin_y_q >= 10'(Y_MAX - 1)) begin
        step_y   = 10'(Y_MAX);
        step_dir = 1'b0;
      end else begin
        step_y   = origin_y_q + 10'd1;
      end
    end else begin
      if (origin_y_q <= 10'(Y_MIN + 1)) begin
        step_y   = 10'(Y_MIN);
        step_dir = 1'b1;
      end else begin
        step_y   = origin_y_q - 10'd1;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      phase_q      <= 7'd0;
      origin_x_q   <= X_HOME_V;
      origin_y_q   <= Y_HOME_V;
      div_cnt      <= '0;
      step_pend    <= 1'b0;
      vsync_q      <= 1'b0;
      frame_tick_q <= 1'b0;
`ifdef SINE_ANIM_BOUNCE_EN
      dir_down     <= 1'b1;
`endif
    end else begin
      vsync_q      <= bus.vsync;
      frame_tick_q <= 1'b0;
      case (state)
        S_IDLE: begin
          step_pend <= 1'b0;
          if (frame_start) begin
            phase_q      <= 7'd0;
            origin_x_q   <= X_HOME_V;
            origin_y_q   <= Y_HOME_V;
            div_cnt      <= '0;
            frame_tick_q <= park_change;
`ifdef SINE_ANIM_BOUNCE_EN
            dir_down     <= 1'b1;
`endif
          end
          if (bus.enable) state <= S_RUN;
        end

        S_RUN: begin
          if (frame_start) begin
            if (div_cnt == DIV_LAST) begin
              phase_q      <= step_phase;
              origin_x_q   <= step_x;
              origin_y_q   <= step_y;
              div_cnt      <= '0;
              frame_tick_q <= 1'b1;
`ifdef SINE_ANIM_BOUNCE_EN
              dir_down     <= step_dir;
`endif
            end else begin
              div_cnt <= div_cnt + DIV_W'(1);
            end
          end
          if (!bus.enable) begin
            state     <= S_IDLE;
            step_pend <= 1'b0;
          end else if (bus.pause) begin
            state <= S_PAUSED;
          end
        end

        S_PAUSED: begin
          // A step_req landing on the frame start itself is consumed directly.
          if (frame_start && (step_pend || bus.step_req)) begin
            phase_q      <= step_phase;
            origin_x_q   <= step_x;
            origin_y_q   <= step_y;
            step_pend    <= 1'b0;
            frame_tick_q <= 1'b1;
`ifdef SINE_ANIM_BOUNCE_EN
            dir_down     <= step_dir;
`endif
          end else if (bus.step_req) begin
            step_pend <= 1'b1;
          end
          if (!bus.enable) begin
            state     <= S_IDLE;
            step_pend <= 1'b0;
          end else if (!bus.pause) begin
            state <= S_RUN;
          end
        end

        default: begin
          state     <= S_IDLE;
          step_pend <= 1'b0;
        end
      endcase
    end
  end

  assign bus.origin_x   = origin_x_q;
  assign bus.origin_y   = origin_y_q;
  assign bus.phase      = phase_q;
  assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_sine_anim_ctrl.sv
module tb_sine_anim_ctrl;
  localparam int X_HOME    = 374;
  localparam int Y_HOME    = 96;
  localparam int Y_MIN     = 32;
  localparam int Y_MAX     = 400;
  localparam int FRAME_DIV = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sine_anim_if bus();

  sine_anim_ctrl #(
    .X_HOME(X_HOME), .Y_HOME(Y_HOME), .Y_MIN(Y_MIN), .Y_MAX(Y_MAX),
    .FRAME_DIV(FRAME_DIV)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int checks = 0;
  int passes = 0;
  int tick_cnt = 0;

  // Behavioural model: mode 0 = parked, 1 = animating, 2 = frozen.
  bit m_valid = 1'b0;
  int m_mode, m_phase, m_y, m_div;
  bit m_down, m_pend, m_vs, m_tick;

  function automatic int exp_x(int p);
    return (X_HOME - p + 1024) % 1024;
  endfunction

  task automatic model_anim_step();
    m_phase = (m_phase + (1 << bus.speed)) % 128;
`ifdef SINE_ANIM_BOUNCE_EN
    if (m_down) begin
      if (m_y >= Y_MAX - 1) begin m_y = Y_MAX; m_down = 1'b0; end
      else m_y = m_y + 1;
    end else begin
      if (m_y <= Y_MIN + 1) begin m_y = Y_MIN; m_down = 1'b1; end
      else m_y = m_y - 1;
    end
`endif
  endtask

  task automatic model_step();
    bit fs;
    bit changed;
    if (rst) begin
      m_valid = 1'b1; m_mode = 0; m_phase = 0; m_y = Y_HOME; m_down = 1'b1;
      m_div = 0; m_pend = 1'b0; m_vs = 1'b0; m_tick = 1'b0;
    end else if (m_valid) begin
      fs = bus.vsync && !m_vs;
      m_vs = bus.vsync;
      m_tick = 1'b0;
      case (m_mode)
        0: begin
          m_pend = 1'b0;
          if (fs) begin
            changed = (m_phase != 0) || (m_y != Y_HOME);
            m_phase = 0; m_y = Y_HOME; m_down = 1'b1; m_div = 0;
            m_tick = changed;
          end
          if (bus.enable) m_mode = 1;
        end
        1: begin
          if (fs) begin
            m_div = m_div + 1;
            if (m_div == FRAME_DIV) begin
              m_div = 0;
              model_anim_step();
              m_tick = 1'b1;
            end
          end
          if (!bus.enable) begin m_mode = 0; m_pend = 1'b0; end
          else if (bus.pause) m_mode = 2;
        end
        default: begin
          if (bus.step_req) m_pend = 1'b1;
          if (fs && m_pend) begin
            model_anim_step();
            m_pend = 1'b0;
            m_tick = 1'b1;
          end
          if (!bus.enable) begin m_mode = 0; m_pend = 1'b0; end
          else if (!bus.pause) m_mode = 1;
        end
      endcase
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Per-cycle comparison of all outputs against the model.
  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      checks++;
      if (bus.origin_x === 10'(exp_x(m_phase)) && bus.origin_y === 10'(m_y) &&
          bus.phase === 7'(m_phase) && bus.frame_tick === m_tick)
        passes++;
      else
        $display("FAIL model_cycle t=%0t got x=%0d y=%0d ph=%0d tick=%0b want x=%0d y=%0d ph=%0d tick=%0b",
                 $time, bus.origin_x, bus.origin_y, bus.phase, bus.frame_tick,
                 exp_x(m_phase), m_y, m_phase, m_tick);
    end
    if (bus.frame_tick === 1'b1) tick_cnt++;
  end

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s got=%0d want=%0d", nm, act, exp);
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic frame(int hi = 2);
    @(negedge clk); bus.vsync = 1'b1;
    repeat (hi) @(negedge clk);
    bus.vsync = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic step_pulse();
    @(negedge clk); bus.step_req = 1'b1;
    @(negedge clk); bus.step_req = 1'b0;
  endtask

  int t0;
  int exp_ph[4] = '{0, 1, 1, 2};
  int exp_tk[4] = '{0, 1, 0, 1};

  initial begin
    rst = 1'b1;
    bus.vsync = 1'b0; bus.enable = 1'b0; bus.pause = 1'b0;
    bus.step_req = 1'b0; bus.speed = 2'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset values
    do_reset();
    chk("rst_phase", int'(bus.phase), 0);
    chk("rst_x", int'(bus.origin_x), 374);
    chk("rst_y", int'(bus.origin_y), 96);
    chk("rst_tick", int'(bus.frame_tick), 0);

    // Frame divider with speed 0
    bus.enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      t0 = tick_cnt;
      frame();
      chk($sformatf("div_phase%0d", i), int'(bus.phase), exp_ph[i]);
      chk($sformatf("div_x%0d", i), int'(bus.origin_x), 374 - exp_ph[i]);
      chk($sformatf("div_tick%0d", i), tick_cnt - t0, exp_tk[i]);
    end

    // Phase wrap at speed 3, via single steps while paused
    do_reset();
    bus.enable = 1'b1; bus.pause = 1'b1; bus.speed = 2'd3;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 15; i++) begin step_pulse(); frame(); end
    chk("ph120", int'(bus.phase), 120);
    chk("x_at120", int'(bus.origin_x), 254);
    t0 = tick_cnt;
    step_pulse(); frame();
    chk("wrap_phase", int'(bus.phase), 0);
    chk("wrap_x", int'(bus.origin_x), 374);
    chk("wrap_tick", tick_cnt - t0, 1);
    step_pulse(); frame();
    chk("ph8_x", int'(bus.origin_x), 366);
`ifndef SINE_ANIM_BOUNCE_EN
    chk("y_held", int'(bus.origin_y), 96);
`endif

    // Paused with no step_req: frozen
    t0 = tick_cnt;
    repeat (6) frame();
    chk("frozen_phase", int'(bus.phase), 8);
    chk("frozen_ticks", tick_cnt - t0, 0);
    step_pulse();
    frame();
    chk("one_step", int'(bus.phase), 16);
    frame();
    chk("one_step_only", int'(bus.phase), 16);

    // step_req in the same cycle as frame_start
    t0 = tick_cnt;
    @(negedge clk); bus.vsync = 1'b1; bus.step_req = 1'b1;
    @(negedge clk); bus.step_req = 1'b0;
    @(negedge clk); bus.vsync = 1'b0;
    repeat (4) @(negedge clk);
    chk("same_cyc_step", int'(bus.phase), 24);
    chk("same_cyc_tick", tick_cnt - t0, 1);
    frame();
    chk("pend_cleared", int'(bus.phase), 24);

    // Enable drop mid-frame at phase 37
    step_pulse(); frame();
    bus.speed = 2'd2; step_pulse(); frame();
    bus.speed = 2'd0; step_pulse(); frame();
    chk("ph37", int'(bus.phase), 37);
    @(negedge clk); bus.enable = 1'b0;
    repeat (3) @(negedge clk);
    chk("drop_hold_phase", int'(bus.phase), 37);
    chk("drop_hold_x", int'(bus.origin_x), 337);
    t0 = tick_cnt;
    frame();
    chk("park_phase", int'(bus.phase), 0);
    chk("park_x", int'(bus.origin_x), 374);
    chk("park_y", int'(bus.origin_y), 96);
    chk("park_tick", tick_cnt - t0, 1);
    t0 = tick_cnt;
    frame();
    chk("repark_no_tick", tick_cnt - t0, 0);

    // Reset mid-run
    bus.enable = 1'b1; bus.pause = 1'b0; bus.speed = 2'd1;
    repeat (4) frame();
    chk("run_phase", int'(bus.phase), 4);
    @(negedge clk); rst = 1'b1; bus.vsync = 1'b1;
    @(negedge clk); rst = 1'b0; bus.vsync = 1'b0;
    chk("midrst_phase", int'(bus.phase), 0);
    chk("midrst_x", int'(bus.origin_x), 374);
    chk("midrst_tick", int'(bus.frame_tick), 0);

    // vsync held high for several frames' worth of clocks
    bus.speed = 2'd0;
    frame();
    chk("hold_pre", int'(bus.phase), 0);
    t0 = tick_cnt;
    frame(21);
    chk("hold_phase", int'(bus.phase), 1);
    chk("hold_ticks", tick_cnt - t0, 1);

`ifdef SINE_ANIM_BOUNCE_EN
    do_reset();
    bus.enable = 1'b1; bus.pause = 1'b1; bus.speed = 2'd0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 303; i++) begin step_pulse(); frame(); end
    chk("y399", int'(bus.origin_y), 399);
    step_pulse(); frame();
    chk("y_max", int'(bus.origin_y), 400);
    step_pulse(); frame();
    chk("y_up", int'(bus.origin_y), 399);
    for (int i = 0; i < 366; i++) begin step_pulse(); frame(); end
    chk("y33", int'(bus.origin_y), 33);
    step_pulse(); frame();
    chk("y_min", int'(bus.origin_y), 32);
    step_pulse(); frame();
    chk("y_down", int'(bus.origin_y), 33);
`endif

    // Randomized stimulus against the model
    do_reset();
    bus.enable = 1'b1; bus.pause = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 5) == 0) bus.vsync = ~bus.vsync;
      if ($urandom_range(0, 60) == 0) bus.enable = ~bus.enable;
      if ($urandom_range(0, 30) == 0) bus.pause = ~bus.pause;
      if ($urandom_range(0, 40) == 0) bus.speed = 2'($urandom_range(0, 3));
      bus.step_req = ($urandom_range(0, 6) == 0);
      rst = ($urandom_range(0, 700) == 0);
    end
    @(negedge clk);
    rst = 1'b0; bus.step_req = 1'b0; bus.vsync = 1'b0;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
